bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Consumes the slow square wave from the board clock divider.
- Runs an MM:SS countdown in BCD, with load, start, pause and clear controls.
- Sits directly downstream of the divider and feeds the 7-segment display driver.
- Everything runs on the 100 MHz board clock; the slow clock is treated as a sampled data input, never as a clock.

Parameters:
- TICKS_PER_SEC, 1: number of SlowClk rising edges per one-second decrement (range 1..255).

Ports:
- Clk  in  1  board clock, 100 MHz.
- Rst  in  1  synchronous, active-low reset, sampled on posedge Clk.
- SlowClk  in  1  divided square wave from the clock divider.
- Load  in  1  load preset digits (single-cycle pulse).
- LdMinT, LdMinO, LdSecT, LdSecO  in  4 each  BCD preset digits.
- Start  in  1  start/resume (single-cycle pulse).
- Pause  in  1  pause (single-cycle pulse).
- Clear  in  1  clear to 00:00 and return to IDLE (single-cycle pulse).
- MinT, MinO, SecT, SecO  out  4 each  current BCD count, registered.
- Running  out  1  high iff state is RUN.
- Done  out  1  high while state is DONE.
- LoadErr  out  1  one-cycle pulse when a Load is rejected.

Behaviour:
- Reset (Rst==0 at posedge Clk):
  - state = IDLE; all digits 0.
  - Running = Done = LoadErr = 0.
  - Prescaler = 0; SlowClk_q = 0.
  - Overrides every other input.
- Edge detect:
  - SlowClk_q <= SlowClk every cycle.
  - Tick = SlowClk & ~SlowClk_q (combinational).
  - Each SlowClk rising edge gives exactly one Tick cycle.
  - Registered effects of a Tick appear after the same Clk edge that samples it.
- States: IDLE, RUN, PAUSE, DONE. 8-bit prescaler.
- Command priority, evaluated per cycle: Clear > Load > Start > Pause > Tick.
  - Only the highest-priority asserted event acts.
  - Lower-priority events in the same cycle are dropped, not queued.
- Clear, any state: digits = 0, prescaler = 0, state = IDLE, Done = 0.
- Load:
  - Acted on only in IDLE or DONE.
  - Valid when every digit <= 9, LdSecT <= 5 and LdMinT <= 5.
  - Valid: digits take the preset values; prescaler = 0; state = IDLE; Done = 0.
  - Invalid, or Load issued in RUN/PAUSE: digits and state unchanged; LoadErr = 1 for the next cycle only.
- Start:
  - IDLE with count != 00:00: go to RUN, prescaler = 0.
  - IDLE with count == 00:00: ignored.
  - PAUSE: go to RUN with the prescaler preserved.
  - RUN or DONE: ignored.
- Pause: RUN goes to PAUSE with prescaler held; ignored in any other state.
- Tick, acts only when the registered state is RUN and no higher-priority command is present:
  - If prescaler == TICKS_PER_SEC-1: prescaler = 0 and decrement once.
  - Otherwise: prescaler += 1.
  - Ticks in IDLE, PAUSE or DONE are discarded.
- BCD decrement (borrow chain):
  - SecO 0 -> 9, borrowing from SecT.
  - SecT 0 -> 5, borrowing from MinO.
  - MinO 0 -> 9, borrowing from MinT.
  - Otherwise the digit decrements by 1.
  - Digits never leave the BCD range.
- Terminal count:
  - The decrement that produces 00:00 also sets state = DONE and Done = 1 on the same edge.
  - Running falls on that same edge.
  - Done holds until Clear or a valid Load.
  - No wrap below 00:00.
- Simultaneous events:
  - Pause with Tick: pause wins, no decrement, prescaler unchanged.
  - Start-from-PAUSE with Tick: Tick discarded.
  - Clear with Load: Clear wins, no LoadErr.
- Reset mid-run: full return to reset values. A SlowClk already high at the first post-reset edge yields a Tick, which is harmless because the state is IDLE.
- Outputs are registered. No combinational path from any input to any output.

Test Plan:
1. Rst=0 for 3 cycles with SlowClk toggling -> all digits 0, Running=Done=LoadErr=0; after release, SlowClk edges change nothing.
2. TICKS_PER_SEC=1; Load 01:05, Start, drive 66 SlowClk rising edges -> sequence 01:05, 01:04 … 01:00, 00:59 … 00:00; Done=1 and Running=0 on the 65th edge; 66th edge causes no change.
3. Load 10:00, Start, one Tick -> 09:59; next Tick -> 09:58.
4. Load with LdSecT=6 (00:60) -> LoadErr high exactly one cycle, digits stay 00:00. Load during RUN -> LoadErr pulse, count continues.
5. TICKS_PER_SEC=4; Load 00:03, Start, 2 ticks, Pause, 5 ticks, Start, 2 ticks -> 00:02. Pause asserted in the same cycle as a Tick -> no decrement.
6. Start at 00:00 -> stays IDLE, Running=0. Clear mid-RUN at 00:42 -> 00:00, IDLE, prescaler 0, subsequent ticks ignored.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer driven by a sampled slow square wave.
// State | meaning: IDLE = stopped, loadable | RUN = counting | PAUSE = held, prescaler kept | DONE = reached 00:00
module bcd_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SlowClk,
  input  logic       Load,
  input  logic [3:0] LdMinT,
  input  logic [3:0] LdMinO,
  input  logic [3:0] LdSecT,
  input  logic [3:0] LdSecO,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  output logic [3:0] MinT,
  output logic [3:0] MinO,
  output logic [3:0] SecT,
  output logic [3:0] SecO,
  output logic       Running,
  output logic       Done,
  output logic       LoadErr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(TICKS_PER_SEC - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt, w_cnt_dec, w_ld_cnt;
  logic [7:0]  r_psc, w_psc_nxt;
  logic        r_slow_q, r_running, r_done, r_loaderr;
  logic        w_loaderr_nxt, w_tick, w_ld_valid;

  assign w_tick     = SlowClk & ~r_slow_q;
  assign w_ld_cnt   = {LdMinT, LdMinO, LdSecT, LdSecO};
  assign w_ld_valid = (LdMinT <= 4'd5) && (LdMinO <= 4'd9) &&
                      (LdSecT <= 4'd5) && (LdSecO <= 4'd9);

  // Borrow chain; only used when the count is non-zero.
  always_comb begin
    w_cnt_dec = r_cnt;
    if (r_cnt[3:0] != 4'd0) begin
      w_cnt_dec[3:0] = r_cnt[3:0] - 4'd1;
    end else begin
      w_cnt_dec[3:0] = 4'd9;
      if (r_cnt[7:4] != 4'd0) begin
        w_cnt_dec[7:4] = r_cnt[7:4] - 4'd1;
      end else begin
        w_cnt_dec[7:4] = 4'd5;
        if (r_cnt[11:8] != 4'd0) begin
          w_cnt_dec[11:8] = r_cnt[11:8] - 4'd1;
        end else begin
          w_cnt_dec[11:8] = 4'd9;
          if (r_cnt[15:12] != 4'd0) w_cnt_dec[15:12] = r_cnt[15:12] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_psc_nxt     = r_psc;
    w_loaderr_nxt = 1'b0;
    if (Clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 16'h0000;
      w_psc_nxt   = 8'd0;
    end else if (Load) begin
      if (((r_state == S_IDLE) || (r_state == S_DONE)) && w_ld_valid) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = w_ld_cnt;
        w_psc_nxt   = 8'd0;
      end else begin
        w_loaderr_nxt = 1'b1;
      end
    end else if (Start) begin
      if ((r_state == S_IDLE) && (r_cnt != 16'h0000)) begin
        w_state_nxt = S_RUN;
        w_psc_nxt   = 8'd0;
      end else if (r_state == S_PAUSE) begin
        w_state_nxt = S_RUN;
      end
    end else if (Pause) begin
      if (r_state == S_RUN) w_state_nxt = S_PAUSE;
    end else if (w_tick && (r_state == S_RUN)) begin
      if (r_psc == LP_LAST) begin
        w_psc_nxt = 8'd0;
        w_cnt_nxt = w_cnt_dec;
        if (w_cnt_dec == 16'h0000) w_state_nxt = S_DONE;
      end else begin
        w_psc_nxt = r_psc + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'h0000;
      r_psc     <= 8'd0;
      r_slow_q  <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_loaderr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_psc     <= w_psc_nxt;
      r_slow_q  <= SlowClk;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
      r_loaderr <= w_loaderr_nxt;
    end
  end

  assign MinT    = r_cnt[15:12];
  assign MinO    = r_cnt[11:8];
  assign SecT    = r_cnt[7:4];
  assign SecO    = r_cnt[3:0];
  assign Running = r_running;
  assign Done    = r_done;
  assign LoadErr = r_loaderr;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: dut_a runs 1 tick/s, dut_b 4 ticks/s, sharing inputs.
module tb_bcd_countdown_timer;

  logic       Clk, Rst, SlowClk, Load, Start, Pause, Clear;
  logic [3:0] LdMinT, LdMinO, LdSecT, LdSecO;
  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic       a_run, a_done, a_le, b_run, b_done, b_le;

  bcd_countdown_timer #(.TICKS_PER_SEC(1)) dut_a (
    .Clk(Clk), .Rst(Rst), .SlowClk(SlowClk), .Load(Load),
    .LdMinT(LdMinT), .LdMinO(LdMinO), .LdSecT(LdSecT), .LdSecO(LdSecO),
    .Start(Start), .Pause(Pause), .Clear(Clear),
    .MinT(a_mt), .MinO(a_mo), .SecT(a_st), .SecO(a_so),
    .Running(a_run), .Done(a_done), .LoadErr(a_le));

  bcd_countdown_timer #(.TICKS_PER_SEC(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .SlowClk(SlowClk), .Load(Load),
    .LdMinT(LdMinT), .LdMinO(LdMinO), .LdSecT(LdSecT), .LdSecO(LdSecO),
    .Start(Start), .Pause(Pause), .Clear(Clear),
    .MinT(b_mt), .MinO(b_mo), .SecT(b_st), .SecO(b_so),
    .Running(b_run), .Done(b_done), .LoadErr(b_le));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;
  string       tag_q[$];
  logic [18:0] exp_q[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [15:0] cnt,
                         input logic run, input logic dn, input logic le);
    tag_q.push_back(tag);
    exp_q.push_back({cnt, run, dn, le});
  endtask

  task automatic sb_pop(input bit use_b);
    string       tag;
    logic [18:0] e, o;
    tag = tag_q.pop_front();
    e   = exp_q.pop_front();
    o   = use_b ? {b_mt, b_mo, b_st, b_so, b_run, b_done, b_le}
                : {a_mt, a_mo, a_st, a_so, a_run, a_done, a_le};
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed cnt=%h run/done/lerr=%b expected cnt=%h run/done/lerr=%b",
                tag, o[18:3], o[2:0], e[18:3], e[2:0]);
  endtask

  task automatic set_ld(input logic [15:0] v);
    {LdMinT, LdMinO, LdSecT, LdSecO} = v;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    set_ld(v); Load = 1'b1; cyc(); Load = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1; cyc(); Start = 1'b0;
  endtask

  task automatic pulse_pause();
    Pause = 1'b1; cyc(); Pause = 1'b0;
  endtask

  task automatic pulse_clear();
    Clear = 1'b1; cyc(); Clear = 1'b0;
  endtask

  task automatic slow_edges(input int n);
    for (int i = 0; i < n; i++) begin
      SlowClk = 1'b1; cyc();
      SlowClk = 1'b0; cyc();
    end
  endtask

  function automatic logic [15:0] secs_to_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  initial begin
    int secs;
    Rst = 1'b0; SlowClk = 1'b0; Load = 1'b0; Start = 1'b0; Pause = 1'b0; Clear = 1'b0;
    set_ld(16'h0000);

    // Reset with SlowClk toggling
    for (int i = 0; i < 3; i++) begin
      SlowClk = ~SlowClk; cyc();
    end
    sb_push("reset_a", 16'h0000, 0, 0, 0); sb_pop(0);
    sb_push("reset_b", 16'h0000, 0, 0, 0); sb_pop(1);
    Rst = 1'b1;
    SlowClk = 1'b0; cyc();
    slow_edges(2);
    sb_push("idle_ticks", 16'h0000, 0, 0, 0); sb_pop(0);

    // 01:05 run to 00:00 at one tick per second
    sb_push("load_0105", 16'h0105, 0, 0, 0); pulse_load(16'h0105); sb_pop(0);
    sb_push("start_0105", 16'h0105, 1, 0, 0); pulse_start(); sb_pop(0);
    secs = 65;
    for (int i = 1; i <= 66; i++) begin
      if (secs > 0) secs--;
      sb_push($sformatf("cd_edge%0d", i), secs_to_bcd(secs), secs > 0, secs == 0, 0);
      slow_edges(1);
      sb_pop(0);
    end

    // 10:00 borrow across every digit
    sb_push("load_1000", 16'h1000, 0, 0, 0); pulse_load(16'h1000); sb_pop(0);
    pulse_start();
    sb_push("dec_0959", 16'h0959, 1, 0, 0); slow_edges(1); sb_pop(0);
    sb_push("dec_0958", 16'h0958, 1, 0, 0); slow_edges(1); sb_pop(0);

    // Load rejected while running
    sb_push("load_in_run", 16'h0958, 1, 0, 1); pulse_load(16'h0500); sb_pop(0);
    sb_push("lerr_one_cyc", 16'h0958, 1, 0, 0); cyc(); sb_pop(0);
    sb_push("run_continues", 16'h0957, 1, 0, 0); slow_edges(1); sb_pop(0);
    sb_push("clear_run", 16'h0000, 0, 0, 0); pulse_clear(); sb_pop(0);
    sb_push("load_0060", 16'h0000, 0, 0, 1); pulse_load(16'h0060); sb_pop(0);
    sb_push("lerr_drop", 16'h0000, 0, 0, 0); cyc(); sb_pop(0);
    sb_push("load_6000", 16'h0000, 0, 0, 1); pulse_load(16'h6000); sb_pop(0);
    cyc();
    sb_push("load_5959", 16'h5959, 0, 0, 0); pulse_load(16'h5959); sb_pop(0);
    pulse_start();
    sb_push("dec_5958", 16'h5958, 1, 0, 0); slow_edges(1); sb_pop(0);

    // Start at zero ignored; Clear mid-run
    pulse_clear();
    sb_push("start_at_zero", 16'h0000, 0, 0, 0); pulse_start(); sb_pop(0);
    sb_push("zero_tick", 16'h0000, 0, 0, 0); slow_edges(1); sb_pop(0);
    pulse_load(16'h0045); pulse_start();
    sb_push("run_0042", 16'h0042, 1, 0, 0); slow_edges(3); sb_pop(0);
    sb_push("clear_0042", 16'h0000, 0, 0, 0); pulse_clear(); sb_pop(0);
    sb_push("after_clear", 16'h0000, 0, 0, 0); slow_edges(2); sb_pop(0);
    pulse_load(16'h0100); pulse_start();
    sb_push("dec_0059", 16'h0059, 1, 0, 0); slow_edges(1); sb_pop(0);

    // Four ticks per second: prescaler hold across pause
    pulse_clear();
    sb_push("b_load_0003", 16'h0003, 0, 0, 0); pulse_load(16'h0003); sb_pop(1);
    sb_push("b_start", 16'h0003, 1, 0, 0); pulse_start(); sb_pop(1);
    slow_edges(2);
    sb_push("b_pause", 16'h0003, 0, 0, 0); pulse_pause(); sb_pop(1);
    sb_push("b_paused_ticks", 16'h0003, 0, 0, 0); slow_edges(5); sb_pop(1);
    sb_push("b_resume", 16'h0003, 1, 0, 0); pulse_start(); sb_pop(1);
    sb_push("b_dec_0002", 16'h0002, 1, 0, 0); slow_edges(2); sb_pop(1);
    sb_push("b_psc3", 16'h0002, 1, 0, 0); slow_edges(3); sb_pop(1);
    Pause = 1'b1; SlowClk = 1'b1; cyc();
    Pause = 1'b0; SlowClk = 1'b0; cyc();
    sb_push("b_pause_tick", 16'h0002, 0, 0, 0); sb_pop(1);
    pulse_start();
    sb_push("b_psc_kept", 16'h0001, 1, 0, 0); slow_edges(1); sb_pop(1);
    pulse_pause();
    Start = 1'b1; SlowClk = 1'b1; cyc();
    Start = 1'b0; SlowClk = 1'b0; cyc();
    sb_push("b_start_tick", 16'h0001, 1, 0, 0); sb_pop(1);
    sb_push("b_three_more", 16'h0001, 1, 0, 0); slow_edges(3); sb_pop(1);
    sb_push("b_done", 16'h0000, 0, 1, 0); slow_edges(1); sb_pop(1);
    sb_push("b_no_wrap", 16'h0000, 0, 1, 0); slow_edges(2); sb_pop(1);
    sb_push("b_load_done", 16'h0007, 0, 0, 0); pulse_load(16'h0007); sb_pop(1);
    set_ld(16'h0009); Load = 1'b1; Clear = 1'b1; cyc();
    Load = 1'b0; Clear = 1'b0;
    sb_push("b_clear_load", 16'h0000, 0, 0, 0); sb_pop(1);
    sb_push("b_no_lerr", 16'h0000, 0, 0, 0); cyc(); sb_pop(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
